exp_host_sequencer: RTL and testbench

- Initiator-side driver for the exponential accelerator's start/done protocol.
- Accepts x operands from an upstream valid/ready stream and launches one accelerator run per operand.
- Waits for the accelerator to return to idle, captures the result and presents it downstream on a valid/ready stream.
- Adds a watchdog timeout, an error flag and a completed-operation counter. Sits between the host-side datapath and the accelerator top.

---
 rtl/exp_host_sequencer.sv | 119 +++++++++++
 tb/tb_exp_host_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_host_sequencer.sv
// Host-side start/done sequencer for the exponential accelerator.
// Launches one run per operand and returns result, error flag and op count.
module exp_host_sequencer #(
    parameter int XW        = 16,
    parameter int RW        = 16,
    parameter int START_LEN = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [XW-1:0] in_x,
    output logic          acc_start,
    output logic [XW-1:0] acc_x,
    input  logic          acc_done,
    input  logic [RW-1:0] acc_result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_result,
    output logic [XW-1:0] out_x,
    output logic          out_err,
    output logic          busy,
    output logic [15:0]   op_count
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE,
        RESULT
    } state_t;

    state_t        state, state_nxt;
    logic [XW-1:0] x_reg;
    logic [RW-1:0] result_reg;
    logic          err_reg;
    logic          seen_low;
    logic [3:0]    lcnt;
    logic [15:0]   tcnt;
    logic          accept, capture, expire;

    assign accept  = (state == IDLE) && in_valid && acc_done;
    assign capture = (state == WAIT_DONE) && seen_low && acc_done;
    assign expire  = (state == WAIT_DONE) && (tcnt == 16'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (accept) state_nxt = LAUNCH;
            LAUNCH:    if (lcnt == 4'd1) state_nxt = WAIT_DONE;
            WAIT_DONE: if (capture || expire) state_nxt = RESULT;
            RESULT:    if (out_ready) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Done seen high before any low is stale and must not be captured.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_reg      <= '0;
            result_reg <= '0;
            err_reg    <= 1'b0;
            seen_low   <= 1'b0;
            lcnt       <= '0;
            tcnt       <= '0;
            op_count   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        x_reg    <= in_x;
                        seen_low <= 1'b0;
                        err_reg  <= 1'b0;
                        lcnt     <= 4'(START_LEN);
                        tcnt     <= '0;
                    end
                end
                LAUNCH: begin
                    lcnt <= lcnt - 4'd1;
                    tcnt <= '0;
                    if (!acc_done) seen_low <= 1'b1;
                end
                WAIT_DONE: begin
                    tcnt <= tcnt + 16'd1;
                    if (!acc_done) seen_low <= 1'b1;
                    if (capture) begin
                        result_reg <= acc_result;
                        err_reg    <= 1'b0;
                    end else if (expire) begin
                        result_reg <= '0;
                        err_reg    <= 1'b1;
                    end
                end
                RESULT: begin
                    if (out_ready) op_count <= op_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready   = (state == IDLE) && acc_done;
        acc_start  = (state == LAUNCH);
        acc_x      = (state == IDLE) ? '0 : x_reg;
        out_valid  = (state == RESULT);
        busy       = (state != IDLE);
        out_result = result_reg;
        out_x      = x_reg;
        out_err    = err_reg;
    end

endmodule

// File: tb/tb_exp_host_sequencer.sv
// Scoreboard bench for exp_host_sequencer with a behavioural accelerator.
// Directed ops cover normal, backpressure, busy, timeout, stale done, reset.
module tb_exp_host_sequencer;

    localparam int M_MAN   = 0;
    localparam int M_NORM  = 1;
    localparam int M_HANG  = 2;
    localparam int M_STALE = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_x = '0;
    logic        acc_start;
    logic [15:0] acc_x;
    logic        acc_done = 1'b1;
    logic [15:0] acc_result = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_result;
    logic [15:0] out_x;
    logic        out_err;
    logic        busy;
    logic [15:0] op_count;

    typedef struct {
        logic [15:0] r;
        logic [15:0] x;
        logic        e;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt = '0;
    int          mode = M_NORM;
    int          busy_len = 14;
    logic [15:0] res_val = '0;
    int          cnt = 0;
    int          sk = 0;
    bit          stale_on = 1'b0;
    int          start_cyc = 0;
    int          wait_cyc = 0;

    exp_host_sequencer #(
        .XW(16), .RW(16), .START_LEN(2), .TIMEOUT(20)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .acc_start(acc_start), .acc_x(acc_x),
        .acc_done(acc_done), .acc_result(acc_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_x(out_x), .out_err(out_err),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Accelerator model, updated 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        case (mode)
            M_NORM: begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        acc_result = res_val;
                        acc_done   = 1'b1;
                    end
                end else if (acc_start && acc_done) begin
                    acc_done = 1'b0;
                    cnt      = busy_len;
                end
            end
            M_HANG: if (acc_start) acc_done = 1'b0;
            M_STALE: begin
                if (!stale_on && acc_start) begin
                    stale_on   = 1'b1;
                    sk         = 0;
                    acc_result = 16'hDEAD;
                end else if (stale_on) begin
                    sk++;
                    if (sk == 3) acc_done = 1'b0;
                    if (sk == 11) begin
                        acc_result = res_val;
                        acc_done   = 1'b1;
                        stale_on   = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always @(posedge clk) begin
        if (acc_start) start_cyc++;
        if (busy && !acc_start && !out_valid) wait_cyc++;
    end

    // Monitor: every output handshake pops one expected entry.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %0h expected none",
                         out_result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_result", 32'(out_result), 32'(e.r));
                chk("out_x", 32'(out_x), 32'(e.x));
                chk("out_err", 32'(out_err), 32'(e.e));
                chk("op_count", 32'(op_count), 32'(exp_cnt));
                exp_cnt = exp_cnt + 16'd1;
            end
        end
    end

    task automatic push(input logic [15:0] r, input logic [15:0] x,
                        input logic e);
        exp_t t;
        t.r = r;
        t.x = x;
        t.e = e;
        exp_q.push_back(t);
    endtask

    task automatic issue(input logic [15:0] x);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_x     = x;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1");
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout: got out_valid 0 expected 1");
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy 1 expected 0");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [15:0] x);
        issue(x);
        wait_idle();
    endtask

    initial begin
        #1;
        chk("reset_outputs",
            32'({acc_start, acc_x, out_valid, out_result, out_x,
                 out_err, busy}), 32'd0);
        chk("reset_op_count", 32'(op_count), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'(acc_done));
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Single normal op
        mode      = M_NORM;
        busy_len  = 14;
        res_val   = 16'h02B7;
        start_cyc = 0;
        push(16'h02B7, 16'h0100, 1'b0);
        run_op(16'h0100);
        chk("start_cycles", 32'(start_cyc), 32'd2);

        // Backpressure in RESULT
        res_val   = 16'h0400;
        out_ready = 1'b0;
        push(16'h0400, 16'h0200, 1'b0);
        issue(16'h0200);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_result", 32'(out_result), 32'h0400);
            chk("bp_x", 32'(out_x), 32'h0200);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_op_count", 32'(op_count), 32'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_idle();
        chk("bp_count_after", 32'(op_count), 32'd2);

        // Accelerator busy when operand arrives
        mode     = M_MAN;
        acc_done = 1'b0;
        res_val  = 16'h0111;
        in_valid = 1'b1;
        in_x     = 16'h0300;
        push(16'h0111, 16'h0300, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("busy_acc_in_ready", 32'(in_ready), 32'd0);
            chk("busy_acc_no_launch", 32'(busy), 32'd0);
        end
        @(posedge clk);
        #1 acc_done = 1'b1;
        mode = M_NORM;
        @(negedge clk);
        chk("done_rise_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 chk("accepted_busy", 32'(busy), 32'd1);
        in_valid = 1'b0;
        wait_idle();

        // Timeout, then a normal op
        mode     = M_HANG;
        wait_cyc = 0;
        push(16'h0000, 16'h0700, 1'b1);
        run_op(16'h0700);
        chk("timeout_wait_cycles", 32'(wait_cyc), 32'd20);
        acc_done = 1'b1;
        mode     = M_NORM;
        res_val  = 16'h0222;
        push(16'h0222, 16'h0800, 1'b0);
        run_op(16'h0800);

        // Stale done after launch
        mode     = M_STALE;
        res_val  = 16'h1234;
        wait_cyc = 0;
        push(16'h1234, 16'h0900, 1'b0);
        run_op(16'h0900);
        chk("stale_wait_cycles", 32'(wait_cyc), 32'd10);
        mode = M_NORM;

        // Reset during WAIT_DONE
        mode = M_HANG;
        issue(16'h0500);
        repeat (5) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("rstw_acc_start", 32'(acc_start), 32'd0);
        chk("rstw_busy", 32'(busy), 32'd0);
        chk("rstw_op_count", 32'(op_count), 32'd0);
        chk("rstw_acc_x", 32'(acc_x), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        acc_done = 1'b1;
        mode     = M_NORM;
        exp_cnt  = '0;
        res_val  = 16'h0333;
        push(16'h0333, 16'h0A00, 1'b0);
        run_op(16'h0A00);

        // Reset during RESULT
        res_val   = 16'h0444;
        out_ready = 1'b0;
        issue(16'h0B00);
        wait_valid();
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("rstr_out_valid", 32'(out_valid), 32'd0);
        chk("rstr_busy", 32'(busy), 32'd0);
        chk("rstr_op_count", 32'(op_count), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        out_ready = 1'b1;
        exp_cnt   = '0;
        res_val   = 16'h0555;
        push(16'h0555, 16'h0C00, 1'b0);
        run_op(16'h0C00);

        repeat (2) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
